inv_sqrt_sched: RTL and testbench
=================================

INV_SQRT_SCHED -- requirements
Module: inv_sqrt_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one inv_sqrt unit.
REQ-002 SHALL have parameter WIDTH, default 32, giving the Q8.24 operand and result width.
REQ-003 SHALL have parameter LATENCY, default 3, giving the clock edges from inv_sqrt sampling x to its inv_sqrt output being valid.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-007 SHALL have port req_ready, output, NUM_REQ bits: per-requester grant, one-hot or zero.
REQ-008 SHALL have port req_x, input, NUM_REQ*WIDTH bits: packed operands, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port res_valid, output, NUM_REQ bits: per-requester result held.
REQ-010 SHALL have port res_ready, input, NUM_REQ bits: per-requester result consumed.
REQ-011 SHALL have port res_data, output, NUM_REQ*WIDTH bits: packed results, same packing as req_x.
REQ-012 SHALL have port sq_x, output, WIDTH bits: registered operand driven to the shared unit.
REQ-013 SHALL have port sq_result, input, WIDTH bits: result returned by the shared unit.
REQ-014 SHALL have port busy, output, 1 bit: OR of all requesters in the INFLIGHT or HOLD state.

Function
REQ-015 SHALL keep one FSM per requester with states IDLE, INFLIGHT and HOLD.
REQ-016 SHALL move a requester IDLE->INFLIGHT on accept, INFLIGHT->HOLD on result capture, and HOLD->IDLE on the edge where res_valid and res_ready are both high.
REQ-017 SHALL treat requester i as eligible only when req_valid[i] is high and its registered state is IDLE.
REQ-018 SHALL not make a requester eligible in the same cycle as its HOLD release; it becomes eligible the following cycle.
REQ-019 SHALL arbitrate round-robin, granting the first eligible index at or after ptr, wrapping modulo NUM_REQ.
REQ-020 SHALL set ptr to grant+1 modulo NUM_REQ after a grant, and leave ptr unchanged when nothing is granted.
REQ-021 SHALL drive req_ready combinationally as the grant; an accept occurs when req_valid and req_ready are high at an edge.
REQ-022 SHALL load sq_x from the granted req_x at the accept edge E0, and otherwise hold sq_x.
REQ-023 SHALL carry a tag pipeline of depth LATENCY+1 (valid bit plus requester index) alongside the unit.
REQ-024 SHALL capture sq_result into res_data of the tagged requester at edge E0+LATENCY+1, so res_valid rises after that edge.
REQ-025 SHALL hold res_data stable while res_valid is high; a result register is never overwritten, because of REQ-017.
REQ-026 SHALL sustain one accept per cycle across requesters, with at most one operation in flight per requester.
REQ-027 SHALL give a single requester a minimum accept-to-accept spacing of LATENCY+3 edges when res_ready is held high.
REQ-028 SHALL pass all operands unmodified, including x=0 (the unit's default path); the block performs no arithmetic.

Reset
REQ-029 SHALL, on rst high and asynchronously, return all FSMs to IDLE, clear the tag pipeline, and set ptr=0, sq_x=0, res_data=0 and res_valid=0.
REQ-030 SHALL force req_ready and busy to 0 while rst is high.
REQ-031 SHALL discard operations in flight when rst is asserted mid-operation; no res_valid is produced for them after release.

Structure
REQ-032 SHALL place the tag record typedef (valid, index of width $clog2(NUM_REQ)), the FSM state enum and the Q8.24 constants in the shared common_defs package.
REQ-033 SHALL implement arbitration as one sub-module, rr_arbiter (eligible vector in; one-hot grant and ptr register out).
REQ-034 SHALL not instantiate inv_sqrt itself; sq_x and sq_result connect to it at the level above.

Verification
REQ-035 SHALL cover: with the unit model LATENCY=3, req 0 sends x=0x01000000 with res_ready=1 -> res_valid[0] high exactly 4 edges after the accept, and res_data[0] equals the model output for 0x01000000.
REQ-036 SHALL cover: all four req_valid high from reset release -> req_ready one-hot 0,1,2,3 on four consecutive cycles, then ptr=0 and no further grants until the results are released.
REQ-037 SHALL cover: req 1 with res_ready[1]=0 for 10 cycles -> res_data[1] stable, req_ready[1]=0 throughout, and reqs 0, 2 and 3 still granted in rotation.
REQ-038 SHALL cover: rst pulsed one cycle after two accepts -> sq_x=0, busy=0, and res_valid stays 0 for the next 8 cycles.
REQ-039 SHALL cover: req 2 sends x=0x00000000 and x=0xFFFFFFFF back to back -> two results returned in order, each equal to the model output, with no extra or dropped res_valid.
REQ-040 SHALL cover: res_ready[0] pulsed in the same cycle req_valid[0] is high -> req_ready[0] stays 0 that cycle and asserts on the next cycle.

Source files
------------

// File: rtl/common_defs.sv
// Shared types and constants for the inv_sqrt request scheduler.
// Holds the per-requester FSM state, the tag record and Q8.24 constants.
package common_defs;

   localparam int DEF_NUM_REQ = 4;
   localparam int TAG_IDX_W   = $clog2(DEF_NUM_REQ);

   localparam int          Q_FRAC_BITS = 24;
   localparam int          Q_WIDTH     = 32;
   localparam logic [31:0] Q_ZERO      = 32'h0000_0000;
   localparam logic [31:0] Q_ONE       = 32'h0100_0000;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_INFLIGHT = 2'd1,
      ST_HOLD     = 2'd2
   } req_state_e;

   typedef struct packed {
      logic                 valid;
      logic [TAG_IDX_W-1:0] idx;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible index at or after ptr.
// Ports: clk, rst (async high), i_elig (eligible vector),
//        o_grant (one-hot or zero), o_ptr (current round-robin pointer).
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         i_elig,
   output logic [N-1:0]         o_grant,
   output logic [$clog2(N)-1:0] o_ptr
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] r_ptr;
   logic          w_any;
   logic [PW-1:0] w_gidx;
   logic [PW-1:0] w_j;

   always_comb begin
      o_grant = '0;
      w_any   = 1'b0;
      w_gidx  = '0;
      w_j     = '0;
      for (int k = 0; k < N; k++) begin
         // Scan order starts at the pointer and wraps modulo N.
         w_j = PW'((int'(r_ptr) + k) % N);
         if (!w_any && i_elig[w_j]) begin
            o_grant[w_j] = 1'b1;
            w_any        = 1'b1;
            w_gidx       = w_j;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_any) begin
         r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + 1'b1;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/inv_sqrt_sched.sv
// Shares one pipelined inv_sqrt unit among NUM_REQ requesters.
// Ports: clk, rst (async high); req_valid/req_ready/req_x operand side;
//        res_valid/res_ready/res_data result side; sq_x/sq_result to the
//        shared unit; busy = any requester in INFLIGHT or HOLD.
module inv_sqrt_sched
   import common_defs::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int LATENCY = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_x,
   output logic [NUM_REQ-1:0]       res_valid,
   input  logic [NUM_REQ-1:0]       res_ready,
   output logic [NUM_REQ*WIDTH-1:0] res_data,
   output logic [WIDTH-1:0]         sq_x,
   input  logic [WIDTH-1:0]         sq_result,
   output logic                     busy
);

   req_state_e r_state     [NUM_REQ];
   req_state_e w_state_nxt [NUM_REQ];
   tag_t       r_tag       [LATENCY+1];
   logic [WIDTH-1:0] r_res [NUM_REQ];
   logic [WIDTH-1:0] r_sq_x;

   logic [NUM_REQ-1:0]         w_elig;
   logic [NUM_REQ-1:0]         w_grant;
   logic [NUM_REQ-1:0]         w_cap;
   logic                       w_any;
   logic [TAG_IDX_W-1:0]       w_gidx;
   logic [WIDTH-1:0]           w_gx;
   logic [$clog2(NUM_REQ)-1:0] w_unused_ptr;

   // Only registered IDLE counts, so a HOLD release waits one cycle.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_elig[i] = req_valid[i] && (r_state[i] == ST_IDLE) && !rst;
      end
   end

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .i_elig  (w_elig),
      .o_grant (w_grant),
      .o_ptr   (w_unused_ptr)
   );

   assign req_ready = w_grant;

   always_comb begin
      w_any  = |w_grant;
      w_gidx = '0;
      w_gx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_gidx = TAG_IDX_W'(i);
            w_gx   = req_x[i*WIDTH +: WIDTH];
         end
      end
   end

   // The oldest tag stage marks whose result sits on sq_result now.
   always_comb begin
      w_cap = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_cap[i] = r_tag[LATENCY].valid &&
                    (r_tag[LATENCY].idx == TAG_IDX_W'(i));
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_state_nxt[i] = r_state[i];
         unique case (r_state[i])
            ST_IDLE:     if (w_grant[i])   w_state_nxt[i] = ST_INFLIGHT;
            ST_INFLIGHT: if (w_cap[i])     w_state_nxt[i] = ST_HOLD;
            ST_HOLD:     if (res_ready[i]) w_state_nxt[i] = ST_IDLE;
            default:                       w_state_nxt[i] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) r_state[i] <= ST_IDLE;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) r_state[i] <= w_state_nxt[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s <= LATENCY; s++) r_tag[s] <= '0;
         r_sq_x <= '0;
      end else begin
         r_tag[0] <= '{valid: w_any, idx: w_gidx};
         for (int s = 1; s <= LATENCY; s++) r_tag[s] <= r_tag[s-1];
         if (w_any) r_sq_x <= w_gx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) r_res[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_cap[i]) r_res[i] <= sq_result;
         end
      end
   end

   always_comb begin
      res_data  = '0;
      res_valid = '0;
      busy      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         res_data[i*WIDTH +: WIDTH] = r_res[i];
         res_valid[i] = (r_state[i] == ST_HOLD);
         if (r_state[i] != ST_IDLE) busy = !rst;
      end
   end

   assign sq_x = r_sq_x;

endmodule

// File: tb/tb_inv_sqrt_sched.sv
// Bench for inv_sqrt_sched: mock unit, transaction-level model,
// directed scenarios and a randomized phase.
module tb_inv_sqrt_sched;
   import common_defs::*;

   localparam int N = 4;
   localparam int W = 32;
   localparam int L = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_x = '0;
   logic [N-1:0]   res_valid;
   logic [N-1:0]   res_ready = '0;
   logic [N*W-1:0] res_data;
   logic [W-1:0]   sq_x;
   logic [W-1:0]   sq_result;
   logic           busy;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   inv_sqrt_sched #(
      .NUM_REQ (N),
      .WIDTH   (W),
      .LATENCY (L)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .sq_x      (sq_x),
      .sq_result (sq_result),
      .busy      (busy)
   );

   // Stand-in for the shared unit: any fixed function works here.
   function automatic logic [W-1:0] unit_f(input logic [W-1:0] x);
      if (x == 0) return 32'h7FFF_FFFF;
      if (x == Q_ONE) return Q_ONE;
      return (x ^ 32'h3C5A_0F00) + 32'd1;
   endfunction

   logic [W-1:0] u_pipe [L] = '{default: '0};
   always @(posedge clk) begin
      u_pipe[0] <= unit_f(sq_x);
      for (int i = 1; i < L; i++) u_pipe[i] <= u_pipe[i-1];
   end
   assign sq_result = u_pipe[L-1];

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Transaction-level model: per requester a countdown to its result
   // and a held flag; grants follow the round-robin rule.
   logic [N-1:0] m_hold = '0;
   int           m_cnt [N] = '{default: 0};
   logic [W-1:0] m_x   [N] = '{default: '0};
   logic [W-1:0] m_exp [N] = '{default: '0};
   logic [W-1:0] m_sqx = '0;
   int           m_ptr = 0;

   always @(negedge clk) begin : mon
      logic [N-1:0] eg;
      logic         eb;
      int           j;
      if (rst) begin
         check("rst_ready", W'(req_ready), 0);
         check("rst_busy", W'(busy), 0);
         check("rst_rvalid", W'(res_valid), 0);
         check("rst_sqx", sq_x, 0);
         m_hold = '0;
         m_ptr  = 0;
         m_sqx  = '0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
         eg = '0;
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (eg == 0 && req_valid[j] && m_cnt[j] == 0 && !m_hold[j])
               eg[j] = 1'b1;
         end
         check("m_ready", W'(req_ready), W'(eg));
         check("m_rvalid", W'(res_valid), W'(m_hold));
         eb = |m_hold;
         for (int i = 0; i < N; i++) if (m_cnt[i] > 0) eb = 1'b1;
         check("m_busy", W'(busy), W'(eb));
         check("m_sqx", sq_x, m_sqx);
         for (int i = 0; i < N; i++)
            if (m_hold[i]) check("m_rdata", res_data[i*W +: W], m_exp[i]);
         for (int i = 0; i < N; i++) begin
            if (m_hold[i] && res_ready[i]) m_hold[i] = 1'b0;
            if (m_cnt[i] > 0) begin
               m_cnt[i]--;
               if (m_cnt[i] == 0) begin
                  m_hold[i] = 1'b1;
                  m_exp[i]  = unit_f(m_x[i]);
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (eg[i]) begin
               m_cnt[i] = L + 1;
               m_x[i]   = req_x[i*W +: W];
               m_sqx    = m_x[i];
               m_ptr    = (i + 1) % N;
            end
         end
      end
   end

   logic [W-1:0] e_q [$];
   bit           e_col = 1'b0;
   always @(negedge clk) begin
      if (e_col && !rst && res_valid[2] && res_ready[2])
         e_q.push_back(res_data[2*W +: W]);
   end

   task automatic set_x(input int i, input logic [W-1:0] v);
      req_x[i*W +: W] = v;
   endtask

   // Returns just after the accept edge.
   task automatic wait_grant(input int i, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready[i] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(tag, W'(req_ready[i]), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic [W-1:0] bx [N];
   logic [N-1:0] seen;
   bit           first;
   int           k;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // single op latency and data
      res_ready = '1;
      set_x(0, Q_ONE);
      req_valid = 4'b0001;
      wait_grant(0, "a_grant");
      req_valid = '0;
      k = 0;
      while (k < 20) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (res_valid[0]) break;
      end
      check("a_latency", W'(k), 4);
      check("a_data", res_data[W-1:0], unit_f(Q_ONE));
      repeat (3) @(posedge clk);
      #1;

      // all four from reset release
      rst       = 1'b1;
      res_ready = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         bx[i] = $urandom;
         set_x(i, bx[i]);
      end
      req_valid = '1;
      for (int c = 0; c < N; c++) begin
         @(negedge clk);
         check("b_grant", W'(req_ready), W'(1 << c));
      end
      repeat (8) begin
         @(negedge clk);
         check("b_nogrant", W'(req_ready), 0);
      end

      // requester 1 holds its result
      @(posedge clk);
      #1;
      res_ready = 4'b1101;
      for (int i = 0; i < N; i++) set_x(i, $urandom);
      seen  = '0;
      first = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("c_data1", res_data[W +: W], unit_f(bx[1]));
         check("c_ready1", W'(req_ready[1]), 0);
         if (first && req_ready != 0) begin
            check("c_first", W'(req_ready), 4'b0001);
            first = 1'b0;
         end
         seen = seen | req_ready;
      end
      check("c_rotation", W'(seen), 4'b1101);
      @(posedge clk);
      #1;
      req_valid = '0;
      res_ready = '1;
      repeat (12) @(posedge clk);
      #1;

      // reset mid-operation
      do_reset();
      set_x(0, $urandom);
      set_x(1, $urandom);
      req_valid = 4'b0011;
      wait_grant(0, "d_grant0");
      wait_grant(1, "d_grant1");
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("d_sqx", sq_x, 0);
      check("d_busy", W'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         check("d_rvalid", W'(res_valid), 0);
      end

      // back-to-back extremes on requester 2
      @(posedge clk);
      #1;
      e_col = 1'b1;
      set_x(2, 32'h0000_0000);
      req_valid = 4'b0100;
      wait_grant(2, "e_grant0");
      set_x(2, 32'hFFFF_FFFF);
      k = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (req_ready[2]) break;
      end
      check("e_spacing", W'(k), L + 3);
      @(posedge clk);
      #1;
      req_valid = '0;
      repeat (12) @(posedge clk);
      #1;
      e_col = 1'b0;
      check("e_count", W'(e_q.size()), 2);
      if (e_q.size() == 2) begin
         check("e_res0", e_q[0], unit_f(32'h0000_0000));
         check("e_res1", e_q[1], unit_f(32'hFFFF_FFFF));
      end

      // release and re-request in the same cycle
      res_ready = '0;
      set_x(0, $urandom);
      req_valid = 4'b0001;
      wait_grant(0, "f_grant");
      k = 0;
      while (!res_valid[0] && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("f_hold", W'(res_valid[0]), 1);
      @(posedge clk);
      #1;
      res_ready[0] = 1'b1;
      @(negedge clk);
      check("f_ready_same", W'(req_ready[0]), 0);
      @(posedge clk);
      #1;
      res_ready[0] = 1'b0;
      @(negedge clk);
      check("f_ready_next", W'(req_ready[0]), 1);
      @(posedge clk);
      #1;
      req_valid = '0;
      res_ready = '1;
      repeat (12) @(posedge clk);
      #1;

      // randomized traffic checked by the model
      repeat (400) begin
         req_valid = N'($urandom);
         res_ready = N'($urandom);
         for (int i = 0; i < N; i++)
            set_x(i, ($urandom_range(0, 7) == 0) ? '0 : $urandom);
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      res_ready = '1;
      repeat (15) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
